mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waiting for dmem_ack before abort.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  EX/MEM outputs carry a live instruction this cycle.
REQ-005 SHALL have port wb_ctlout  in  2  [1]=regwrite, [0]=memtoreg.
REQ-006 SHALL have ports branch, memread, memwrite, zero  in  1 each  EX/MEM control and ALU zero flag.
REQ-007 SHALL have ports alu_result, rdata2out  in  32 each  address/ALU value; store data.
REQ-008 SHALL have port five_bit_muxout  in  5  destination register.
REQ-009 SHALL have port pcsrc  out  1  taken-branch select to IF.
REQ-010 SHALL have port stall  out  1  upstream hold request.
REQ-011 SHALL have ports dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  32 each; dmem_ack  in  1; dmem_rdata  in  32: data-memory handshake.
REQ-012 SHALL have ports valid_out  out  1; wb_ctl_out  out  2; read_data, alu_out  out  32 each; write_reg  out  5: MEM/WB register.
REQ-013 SHALL have port mem_err  out  1  sticky error flag.

Function
REQ-014 SHALL drive pcsrc = in_valid & branch & zero, combinationally, independent of state.
REQ-015 SHALL implement FSM IDLE, WAIT; "mem op" = in_valid & (memread|memwrite); "aligned" = alu_result[1:0]==0.
REQ-016 IDLE, in_valid, no mem op: SHALL load MEM/WB register next edge with valid_out=1, read_data=0, other fields passed through; latency 1 cycle.
REQ-017 IDLE, aligned mem op: SHALL latch address, wdata, dest, wb_ctl, we=memwrite (write wins if both set); go to WAIT; valid_out=0 next cycle.
REQ-018 IDLE, misaligned mem op: SHALL not access memory; load MEM/WB with valid_out=1, wb_ctl_out=00; set mem_err.
REQ-019 stall SHALL be 1 in WAIT and in the IDLE cycle accepting an aligned mem op, else 0.
REQ-020 WAIT: dmem_req=1 with latched addr/we/wdata held stable every cycle; dmem_req=0 in IDLE.
REQ-021 WAIT, dmem_ack=1: SHALL load MEM/WB (valid_out=1, read_data=dmem_rdata if read else 0) and return to IDLE; dmem_req low next cycle.
REQ-022 WAIT SHALL count cycles from 0; at TIMEOUT cycles without ack: return to IDLE, valid_out=1 with wb_ctl_out=00, mem_err set.
REQ-023 Ack and timeout in same cycle: ack SHALL win.
REQ-024 Inputs in WAIT SHALL be ignored (upstream holds); dmem_ack in IDLE SHALL be ignored.
REQ-025 valid_out SHALL be a one-cycle pulse per retired instruction; 0 in any cycle not loading MEM/WB.
REQ-026 mem_err SHALL stay 1 until reset.

Reset
REQ-027 On rst: state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, valid_out=0, wb_ctl_out=0, read_data=0, alu_out=0, write_reg=0, mem_err=0.
REQ-028 Reset in WAIT SHALL abort: dmem_req 0 next cycle, no valid_out, no mem_err.
REQ-029 Reset SHALL override all simultaneous events; pcsrc remains combinational.

Structure
REQ-030 Package mem_stage_pkg SHALL hold state encoding, wb_ctl bit indices (REGWRITE=1, MEMTOREG=0), default TIMEOUT.
REQ-031 MEM/WB output register SHALL be sub-module mem_wb_reg (load-enable, sync reset); FSM and counter stay in mem_stage.

Verification
REQ-032 R-type: in_valid=1, wb=10, alu_result=0x2A, dest=5 -> next cycle valid_out=1, alu_out=0x2A, write_reg=5, read_data=0, stall=0.
REQ-033 Load: memread, addr=0x100, ack after 3 WAIT cycles with rdata=0xDEADBEEF -> stall high 4 cycles, dmem_req high 3, then valid_out=1, read_data=0xDEADBEEF.
REQ-034 Store misaligned addr=0x103 -> no dmem_req, valid_out=1, wb_ctl_out=00, mem_err=1 stays set.
REQ-035 No ack for 16 WAIT cycles -> dmem_req drops, valid_out=1 with wb_ctl_out=00, mem_err=1; ack on cycle 16 instead -> normal completion, mem_err=0.
REQ-036 rst during WAIT -> next cycle dmem_req=0, stall=0, valid_out=0, mem_err=0.
REQ-037 branch=1, zero=1, in_valid=1 -> pcsrc=1 same cycle; zero=0 -> pcsrc=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
//============================================================================
// Module      : mem_stage_pkg
// Description : Shared definitions for the MEM pipeline stage: FSM state
//               encoding, write-back control bit positions, default memory
//               timeout and the MEM/WB payload record.
// Revision    : 1.0 - initial release
//============================================================================
package mem_stage_pkg;

    // Default number of WAIT cycles tolerated before a memory access aborts
    localparam int c_TIMEOUT_DEFAULT = 16;

    // FSM state encoding
    localparam int                   c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_S_IDLE  = 1'b0;
    localparam logic [c_STATE_W-1:0] c_S_WAIT  = 1'b1;

    // Bit positions inside the 2-bit write-back control field
    localparam int c_REGWRITE = 1;
    localparam int c_MEMTOREG = 0;

    // Everything the MEM/WB register captures besides its valid bit
    typedef struct packed {
        logic [1:0]  wb_ctl;
        logic [31:0] read_data;
        logic [31:0] alu_out;
        logic [4:0]  write_reg;
    } memwb_t;

    // Word accesses need the two low address bits clear
    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
//============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register. A load pulse captures a payload
//               and raises valid_out for exactly one cycle; without a load
//               valid_out returns low while the data fields hold.
// Revision    : 1.0 - initial release
//============================================================================
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  memwb_t      d,
    output logic        valid_out,
    output logic [1:0]  wb_ctl_out,
    output logic [31:0] read_data,
    output logic [31:0] alu_out,
    output logic [4:0]  write_reg
);

    logic   r_valid;
    memwb_t r_q;

    // Capture payload on load; valid is a single-cycle pulse per load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else begin
            r_valid <= load;
            if (load) begin
                r_q <= d;
            end
        end
    end

    assign valid_out  = r_valid;
    assign wb_ctl_out = r_q.wb_ctl;
    assign read_data  = r_q.read_data;
    assign alu_out    = r_q.alu_out;
    assign write_reg  = r_q.write_reg;

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
//============================================================================
// Module      : mem_stage
// Description : MEM pipeline stage. Resolves the branch select, runs the
//               data-memory request/acknowledge handshake with a bounded
//               wait, stalls upstream while an access is outstanding and
//               retires each instruction into the MEM/WB register.
// Revision    : 1.0 - initial release
//============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  wb_ctlout,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic [1:0]  wb_ctl_out,
    output logic [31:0] read_data,
    output logic [31:0] alu_out,
    output logic [4:0]  write_reg,
    output logic        mem_err
);

    // Counter holds 0..TIMEOUT-1; reaching the last value without an ack aborts
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;

    // Access latched at issue and held on the memory port through WAIT
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [4:0]  r_dest;
    logic [1:0]  r_wb;
    logic        r_err;

    logic        w_mem_op;
    logic        w_aligned;
    logic        w_issue;
    logic        w_timeout;
    logic        w_load;
    logic        w_err_set;
    memwb_t      w_memwb;

    assign w_mem_op  = in_valid & (memread | memwrite);
    assign w_aligned = is_aligned(alu_result[1:0]);
    assign w_issue   = (r_state == c_S_IDLE) & w_mem_op & w_aligned;
    assign w_timeout = (r_cnt == c_CNT_LAST);

    // Branch decision is purely combinational and ignores the FSM
    assign pcsrc = in_valid & branch & zero;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: leave IDLE on an aligned access, leave WAIT on ack or timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_mem_op && w_aligned) begin
                    w_next_state = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (dmem_ack || w_timeout) begin
                    w_next_state = c_S_IDLE;
                end
            end
            default: w_next_state = c_S_IDLE;
        endcase
    end

    // Outputs: stall/request, MEM/WB load and payload, error set
    always_comb begin
        stall     = 1'b0;
        dmem_req  = 1'b0;
        w_load    = 1'b0;
        w_err_set = 1'b0;
        w_memwb   = '0;
        case (r_state)
            c_S_IDLE: begin
                if (in_valid) begin
                    if (!w_mem_op) begin
                        // Non-memory instruction passes straight through
                        w_load            = 1'b1;
                        w_memwb.wb_ctl    = wb_ctlout;
                        w_memwb.alu_out   = alu_result;
                        w_memwb.write_reg = five_bit_muxout;
                    end else if (w_aligned) begin
                        stall = 1'b1;
                    end else begin
                        // Misaligned: retire without touching memory, suppress write-back
                        w_load                        = 1'b1;
                        w_err_set                     = 1'b1;
                        w_memwb.wb_ctl                = wb_ctlout;
                        w_memwb.wb_ctl[c_REGWRITE]    = 1'b0;
                        w_memwb.wb_ctl[c_MEMTOREG]    = 1'b0;
                        w_memwb.alu_out               = alu_result;
                        w_memwb.write_reg             = five_bit_muxout;
                    end
                end
            end
            c_S_WAIT: begin
                stall    = 1'b1;
                dmem_req = 1'b1;
                w_memwb.alu_out   = r_addr;
                w_memwb.write_reg = r_dest;
                if (dmem_ack) begin
                    w_load            = 1'b1;
                    w_memwb.wb_ctl    = r_wb;
                    w_memwb.read_data = r_we ? 32'd0 : dmem_rdata;
                end else if (w_timeout) begin
                    w_load                     = 1'b1;
                    w_err_set                  = 1'b1;
                    w_memwb.wb_ctl             = r_wb;
                    w_memwb.wb_ctl[c_REGWRITE] = 1'b0;
                    w_memwb.wb_ctl[c_MEMTOREG] = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Latch the access when it is accepted; write wins when both flags are set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_dest  <= '0;
            r_wb    <= '0;
        end else if (w_issue) begin
            r_addr  <= alu_result;
            r_wdata <= rdata2out;
            r_we    <= memwrite;
            r_dest  <= five_bit_muxout;
            r_wb    <= wb_ctlout;
        end
    end

    // Count WAIT cycles without ack; cleared whenever WAIT is left or not active
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == c_S_WAIT) && !dmem_ack && !w_timeout) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign mem_err    = r_err;

    mem_wb_reg u_mem_wb_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .d          (w_memwb),
        .valid_out  (valid_out),
        .wb_ctl_out (wb_ctl_out),
        .read_data  (read_data),
        .alu_out    (alu_out),
        .write_reg  (write_reg)
    );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: transaction-level model
//               with a per-cycle compare process, plus directed scenarios
//               with hand-computed literal expectations.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mem_stage;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        pcsrc, stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        valid_out;
    logic [1:0]  wb_ctl_out;
    logic [31:0] read_data, alu_out;
    logic [4:0]  write_reg;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .wb_ctlout       (wb_ctlout),
        .branch          (branch),
        .memread         (memread),
        .memwrite        (memwrite),
        .zero            (zero),
        .alu_result      (alu_result),
        .rdata2out       (rdata2out),
        .five_bit_muxout (five_bit_muxout),
        .pcsrc           (pcsrc),
        .stall           (stall),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata),
        .valid_out       (valid_out),
        .wb_ctl_out      (wb_ctl_out),
        .read_data       (read_data),
        .alu_out         (alu_out),
        .write_reg       (write_reg),
        .mem_err         (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_store;
        logic [4:0]  dest;
        logic [1:0]  wb;
    } access_t;

    bit          model_on = 0;
    bit          busy     = 0;   // an access is outstanding on the memory port
    int          waited   = 0;   // WAIT cycles spent on the outstanding access
    access_t     pend;
    bit          err      = 0;
    bit          e_valid  = 0;
    logic [1:0]  e_wb     = '0;
    logic [31:0] e_rd     = '0;
    logic [31:0] e_alu    = '0;
    logic [4:0]  e_wr     = '0;

    function automatic void retire(input logic [1:0] wb, input logic [31:0] rd,
                                   input logic [31:0] alu, input logic [4:0] wr);
        e_valid = 1; e_wb = wb; e_rd = rd; e_alu = alu; e_wr = wr;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1;
            busy = 0; waited = 0; err = 0;
            e_valid = 0; e_wb = '0; e_rd = '0; e_alu = '0; e_wr = '0;
        end else begin
            e_valid = 0;
            if (busy) begin
                waited++;
                if (dmem_ack) begin
                    retire(pend.wb, pend.is_store ? 32'd0 : dmem_rdata, pend.addr, pend.dest);
                    busy = 0;
                end else if (waited == TIMEOUT) begin
                    retire(2'b00, 32'd0, pend.addr, pend.dest);
                    err = 1;
                    busy = 0;
                end
            end else if (in_valid) begin
                if (!memread && !memwrite) begin
                    retire(wb_ctlout, 32'd0, alu_result, five_bit_muxout);
                end else if (alu_result % 4 != 0) begin
                    retire(2'b00, 32'd0, alu_result, five_bit_muxout);
                    err = 1;
                end else begin
                    busy = 1; waited = 0;
                    pend.addr = alu_result; pend.wdata = rdata2out;
                    pend.is_store = memwrite; pend.dest = five_bit_muxout;
                    pend.wb = wb_ctlout;
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_pcsrc", pcsrc, in_valid && branch && zero);
            chk("m_stall", stall,
                busy || (in_valid && (memread || memwrite) && alu_result % 4 == 0));
            chk("m_dmem_req", dmem_req, busy);
            chk("m_valid_out", valid_out, e_valid);
            chk("m_mem_err", mem_err, err);
            if (busy) begin
                chk("m_dmem_addr", dmem_addr, pend.addr);
                chk("m_dmem_we", dmem_we, pend.is_store);
                if (pend.is_store) chk("m_dmem_wdata", dmem_wdata, pend.wdata);
            end
            if (e_valid) begin
                chk("m_wb_ctl_out", wb_ctl_out, e_wb);
                chk("m_read_data", read_data, e_rd);
                chk("m_alu_out", alu_out, e_alu);
                chk("m_write_reg", write_reg, e_wr);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; wb_ctlout = 2'b00; branch = 0; memread = 0; memwrite = 0;
        zero = 0; alu_result = '0; rdata2out = '0; five_bit_muxout = '0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Issue one aligned access; ack arrives in WAIT cycle ack_on (0 = never)
    task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] wb, input int ack_on, input logic [31:0] rdata,
                          output int n_stall, output int n_req);
        int wait_len;
        wait_len = (ack_on == 0) ? TIMEOUT : ack_on;
        n_stall = 0; n_req = 0;
        cyc();
        in_valid = 1; memread = !wr; memwrite = wr; alu_result = addr;
        rdata2out = wdata; wb_ctlout = wb; five_bit_muxout = 5'd9; dmem_ack = 0;
        @(negedge clk);
        if (stall) n_stall++;
        if (dmem_req) n_req++;
        for (int c = 1; c <= wait_len; c++) begin
            cyc();
            alu_result = ~addr;          // garbage while waiting must be ignored
            rdata2out  = ~wdata;
            dmem_ack   = (c == ack_on);
            dmem_rdata = rdata;
            @(negedge clk);
            if (stall) n_stall++;
            if (dmem_req) n_req++;
        end
        cyc();
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        int ns, nr;
        rst = 1;
        idle_inputs();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_addr", dmem_addr, 0);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_mem_err", mem_err, 0);

        // R-type pass-through
        cyc(); rst = 0;
        in_valid = 1; wb_ctlout = 2'b10; alu_result = 32'h2A; five_bit_muxout = 5'd5;
        @(negedge clk);
        chk("rtype_stall", stall, 0);
        cyc(); idle_inputs();
        @(negedge clk);
        chk("rtype_valid", valid_out, 1);
        chk("rtype_alu_out", alu_out, 32'h2A);
        chk("rtype_write_reg", write_reg, 5);
        chk("rtype_read_data", read_data, 0);
        chk("rtype_wb", wb_ctl_out, 2'b10);
        dmem_ack = 1;                    // ack while idle is ignored
        cyc(); dmem_ack = 0;
        @(negedge clk);
        chk("rtype_pulse", valid_out, 0);

        // Load, ack in third WAIT cycle
        do_mem(1'b0, 32'h100, 32'h0, 2'b11, 3, 32'hDEADBEEF, ns, nr);
        chk("load_stall_cycles", ns, 4);
        chk("load_req_cycles", nr, 3);
        chk("load_valid", valid_out, 1);
        chk("load_read_data", read_data, 32'hDEADBEEF);
        chk("load_alu_out", alu_out, 32'h100);

        // Aligned store, ack at once: read_data must be 0
        do_mem(1'b1, 32'h200, 32'h12345678, 2'b00, 1, 32'hCAFEF00D, ns, nr);
        chk("store_req_cycles", nr, 1);
        chk("store_read_data", read_data, 0);

        // Ack exactly on the last allowed WAIT cycle completes normally
        do_mem(1'b0, 32'h40, 32'h0, 2'b11, TIMEOUT, 32'hA5A5A5A5, ns, nr);
        chk("late_ack_req_cycles", nr, 16);
        chk("late_ack_stall_cycles", ns, 17);
        chk("late_ack_wb", wb_ctl_out, 2'b11);
        chk("late_ack_read_data", read_data, 32'hA5A5A5A5);
        chk("late_ack_mem_err", mem_err, 0);

        // Misaligned store never touches memory
        cyc();
        in_valid = 1; memwrite = 1; alu_result = 32'h103; wb_ctlout = 2'b10;
        five_bit_muxout = 5'd3;
        @(negedge clk);
        chk("mis_stall", stall, 0);
        chk("mis_req", dmem_req, 0);
        cyc(); idle_inputs();
        @(negedge clk);
        chk("mis_valid", valid_out, 1);
        chk("mis_wb", wb_ctl_out, 2'b00);
        chk("mis_err", mem_err, 1);
        chk("mis_req_after", dmem_req, 0);
        cyc(); cyc();
        @(negedge clk);
        chk("mis_err_sticky", mem_err, 1);

        // Timeout after a reset clears the flag
        cyc(); rst = 1;
        cyc(); rst = 0;
        @(negedge clk);
        chk("rst2_mem_err", mem_err, 0);
        do_mem(1'b0, 32'h80, 32'h0, 2'b11, 0, 32'h0, ns, nr);
        chk("tmo_req_cycles", nr, 16);
        chk("tmo_valid", valid_out, 1);
        chk("tmo_wb", wb_ctl_out, 2'b00);
        chk("tmo_mem_err", mem_err, 1);
        chk("tmo_req_dropped", dmem_req, 0);

        // Reset during WAIT aborts the access
        cyc();
        in_valid = 1; memread = 1; alu_result = 32'h300; wb_ctlout = 2'b11;
        cyc(); cyc();
        @(negedge clk);
        chk("rstw_in_wait", dmem_req, 1);
        cyc(); rst = 1; idle_inputs();
        cyc(); rst = 0;
        @(negedge clk);
        chk("rstw_req", dmem_req, 0);
        chk("rstw_stall", stall, 0);
        chk("rstw_valid", valid_out, 0);
        chk("rstw_mem_err", mem_err, 0);

        // Branch select
        cyc();
        in_valid = 1; branch = 1; zero = 1;
        #1;
        chk("br_taken", pcsrc, 1);
        zero = 0;
        #1;
        chk("br_not_taken", pcsrc, 0);
        cyc(); idle_inputs();
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
